// File: rtl/byte_lane_data_mem.sv
// byte_lane_data_mem: byte-addressed little-endian RV32I data memory.
// Handles byte, halfword and word loads and stores, with a zero-clear
// sequencer that runs after reset and holds busy high until the clear ends.
// Optional macro DMEM_MISALIGN_EXC_EN: when defined, misaligned half/word
// accesses raise misalign, their stores are dropped and their loads return 0.
// When the macro is undefined, misalign is tied low and half/word accesses
// are forced onto their natural alignment.
//
// state | meaning
// ------+-------------------------------------------------------------
// CLEAR | zero word[ptr] each cycle, core stalled (busy=1), we/re ignored
// READY | normal load/store service, busy=0
module byte_lane_data_mem #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic              we,
    input  logic              re,
    input  logic [2:0]        funct3,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic              misalign
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [31:0]      mem [DEPTH];

    logic [IDX_W-1:0] idx;
    logic             ready;
    logic             half_acc;
    logic             word_acc;
    logic             mis_raw;
    logic             store_ok;
    logic [3:0]       byte_en;
    logic [31:0]      wlane;
    logic [31:0]      word;
    logic [31:0]      shifted;
    logic [15:0]      half;

    // Address bits above the word index only alias the same storage.
    generate
        if (ADDR_W > IDX_W + 2) begin : g_hi_addr
            logic unused_hi_addr;
            assign unused_hi_addr = ^addr[ADDR_W-1:IDX_W+2];
        end
    endgenerate

    assign idx      = addr[2 +: IDX_W];
    assign ready    = (state == READY);
    assign half_acc = (funct3 == 3'b001) || (funct3 == 3'b101);
    assign word_acc = (funct3 == 3'b010);

`ifdef DMEM_MISALIGN_EXC_EN
    assign mis_raw = (half_acc & addr[0]) | (word_acc & (addr[1:0] != 2'b00));
`else
    assign mis_raw = 1'b0;
`endif

    assign misalign = ready & (re | we) & mis_raw;
    assign store_ok = ready & we & ~mis_raw;

    // Clear sequencer: sweep ptr over every word, then hand over to READY.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == LAST_IDX) begin
                        state <= READY;
                        busy  <= 1'b0;
                    end
                end
                READY: begin
                    busy <= 1'b0;
                end
                default: begin
                    state <= CLEAR;
                    ptr   <= '0;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    // Store lane enables and lane-replicated write data; half/word lane
    // selection ignores the low address bits so unaligned accesses fold
    // onto their aligned container when the misalign check is off.
    always_comb begin
        byte_en = 4'b0000;
        wlane   = 32'h0;
        case (funct3)
            3'b000: begin
                byte_en = 4'b0001 << addr[1:0];
                wlane   = {4{wdata[7:0]}};
            end
            3'b001: begin
                byte_en = addr[1] ? 4'b1100 : 4'b0011;
                wlane   = {2{wdata[15:0]}};
            end
            3'b010: begin
                byte_en = 4'b1111;
                wlane   = wdata;
            end
            default: begin
                byte_en = 4'b0000;
                wlane   = 32'h0;
            end
        endcase
    end

    // Memory write port: zero fill while clearing, lane-masked stores when
    // ready; nothing is written while rst is held.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[ptr] <= 32'h0;
            end else if (store_ok) begin
                for (int i = 0; i < 4; i++) begin
                    if (byte_en[i]) begin
                        mem[idx][8*i +: 8] <= wlane[8*i +: 8];
                    end
                end
            end
        end
    end

    assign word    = mem[idx];
    assign shifted = word >> {addr[1:0], 3'b000};
    assign half    = addr[1] ? word[31:16] : word[15:0];

    // Asynchronous load path; a same-edge store is seen only after the edge.
    always_comb begin
        rdata = 32'h0;
        if (ready && re && !mis_raw) begin
            case (funct3)
                3'b000:  rdata = {{24{shifted[7]}}, shifted[7:0]};
                3'b001:  rdata = {{16{half[15]}}, half};
                3'b010:  rdata = word;
                3'b100:  rdata = {24'h0, shifted[7:0]};
                3'b101:  rdata = {16'h0, half};
                default: rdata = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_lane_data_mem.sv
// Directed bench for byte_lane_data_mem with DEPTH=16; adapts misalign
// expectations to whether DMEM_MISALIGN_EXC_EN is defined.
module tb_byte_lane_data_mem;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [2:0]  funct3;
    logic [31:0] rdata;
    logic        busy;
    logic        misalign;

    int n_checks;
    int n_fail;

    byte_lane_data_mem #(
        .DEPTH  (16),
        .ADDR_W (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .wdata    (wdata),
        .we       (we),
        .re       (re),
        .funct3   (funct3),
        .rdata    (rdata),
        .busy     (busy),
        .misalign (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Store one access at the next rising edge; returns at the following negedge.
    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
        addr   = a;
        wdata  = d;
        funct3 = f3;
        we     = 1'b1;
        re     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [31:0] a, input logic [2:0] f3,
                           input logic [31:0] exp);
        addr   = a;
        funct3 = f3;
        re     = 1'b1;
        we     = 1'b0;
        #1;
        check_eq(tag, rdata, exp);
        re = 1'b0;
    endtask

    // Counts negedge samples with busy high, starting from the current one.
    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        n_checks = 0;
        n_fail   = 0;
        rst    = 1'b1;
        addr   = 32'h0;
        wdata  = 32'h0;
        we     = 1'b0;
        re     = 1'b0;
        funct3 = 3'b010;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_busy", {31'h0, busy}, 32'h1);
        check_eq("reset_misalign", {31'h0, misalign}, 32'h0);
        check_eq("reset_rdata", rdata, 32'h0);

        // Clear sequence, with a load request that must read 0 during CLEAR.
        rst = 1'b0;
        re  = 1'b1;
        @(negedge clk);
        check_eq("clear_rdata", rdata, 32'h0);
        re = 1'b0;
        count_busy(cnt);
        check_eq("clear_busy_cycles", cnt, 32'd15);
        check_eq("clear_busy_done", {31'h0, busy}, 32'h0);

        for (int i = 0; i < 16; i++) begin
            do_load($sformatf("clear_word%0d", i), i * 4, 3'b010, 32'h0);
        end

        // Byte lanes
        do_store(32'h8, 32'h11223344, 3'b010);
        do_store(32'hB, 32'h000000AA, 3'b000);
        do_load("lw_8", 32'h8, 3'b010, 32'hAA223344);
        do_load("lb_b", 32'hB, 3'b000, 32'hFFFFFFAA);
        do_load("lbu_b", 32'hB, 3'b100, 32'h000000AA);
        do_load("lb_9", 32'h9, 3'b000, 32'h00000033);
        do_load("lh_8", 32'h8, 3'b001, 32'h00003344);
        do_load("bad_f3_load", 32'h8, 3'b011, 32'h0);
        addr = 32'h8; funct3 = 3'b010; re = 1'b0; #1;
        check_eq("re_low", rdata, 32'h0);
        do_store(32'h8, 32'hFFFFFFFF, 3'b011);
        do_load("bad_f3_store", 32'h8, 3'b010, 32'hAA223344);

        // Halfwords
        do_store(32'h6, 32'h00008001, 3'b001);
        do_load("lh_6", 32'h6, 3'b001, 32'hFFFF8001);
        do_load("lhu_6", 32'h6, 3'b101, 32'h00008001);
        do_load("lw_4", 32'h4, 3'b010, 32'h80010000);

        // Wrap and same-cycle store/load
        do_store(32'h40, 32'hDEADBEEF, 3'b010);
        do_load("wrap_lw_0", 32'h0, 3'b010, 32'hDEADBEEF);
        addr = 32'h0; funct3 = 3'b010; wdata = 32'h12345678; we = 1'b1; re = 1'b1;
        #1;
        check_eq("bypass_old", rdata, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        check_eq("bypass_new", rdata, 32'h12345678);
        @(negedge clk);
        we = 1'b0; re = 1'b0;

        // Misaligned accesses: LW @0x2, SH 0x5555 @0x1
        addr = 32'h2; funct3 = 3'b010; re = 1'b1; #1;
`ifdef DMEM_MISALIGN_EXC_EN
        check_eq("mis_lw_flag", {31'h0, misalign}, 32'h1);
        check_eq("mis_lw_data", rdata, 32'h0);
`else
        check_eq("mis_lw_flag", {31'h0, misalign}, 32'h0);
        check_eq("mis_lw_data", rdata, 32'h12345678);
`endif
        re = 1'b0;
        addr = 32'h1; funct3 = 3'b001; wdata = 32'h00005555; we = 1'b1; #1;
`ifdef DMEM_MISALIGN_EXC_EN
        check_eq("mis_sh_flag", {31'h0, misalign}, 32'h1);
`else
        check_eq("mis_sh_flag", {31'h0, misalign}, 32'h0);
`endif
        @(posedge clk);
        @(negedge clk);
        we = 1'b0;
`ifdef DMEM_MISALIGN_EXC_EN
        do_load("mis_sh_mem", 32'h0, 3'b010, 32'h12345678);
`else
        do_load("mis_sh_mem", 32'h0, 3'b010, 32'h12345555);
`endif

        // Mid-clear reset with stores requested throughout CLEAR
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        addr = 32'h10; funct3 = 3'b010; wdata = 32'hFFFFFFFF; we = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("midclear_busy", {31'h0, busy}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        count_busy(cnt);
        we = 1'b0;
        check_eq("midclear_busy_cycles", cnt, 32'd16);
        do_load("midclear_w4", 32'h10, 3'b010, 32'h0);
        do_load("midclear_w2", 32'h8, 3'b010, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
